// File: rtl/cam_frame_ctrl.sv
// Frame sequencer: waits for sensor config, drops settling frames, then gates capture_en on vsync boundaries and checks per-frame line/byte counts.
// Outputs are registered and change one pclk after the vsync/href edge is seen; there is no backpressure.
module cam_frame_ctrl #(
   parameter int SKIP_FRAMES = 2,
   parameter int EXP_LINES   = 480,
   parameter int EXP_BYTES   = 1280
) (
   input  logic        pclk,
   input  logic        reset,
   input  logic        config_done,
   input  logic        vsync,
   input  logic        href,
   input  logic        start,
   input  logic        stop,
   input  logic        continuous,
   output logic        capture_en,
   output logic        busy,
   output logic        frame_start,
   output logic        frame_done,
   output logic        frame_err,
   output logic [15:0] frame_count,
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {
      WAIT_CFG = 3'd0,
      SKIP     = 3'd1,
      IDLE     = 3'd2,
      ARM      = 3'd3,
      ACTIVE   = 3'd4
   } state_t;

   localparam int SKW = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;
   localparam logic [SKW-1:0] SKIP_LAST = SKW'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);
   localparam logic [9:0]  EXP_L = 10'(EXP_LINES);
   localparam logic [10:0] EXP_B = 11'(EXP_BYTES);

   state_t         state_q, state_d;
   logic           vsync_q, href_q;
   logic [SKW-1:0] skip_cnt_q, skip_cnt_d;
   logic           cont_q, cont_d;
   logic [9:0]     line_cnt_q, line_cnt_d;
   logic [10:0]    byte_cnt_q, byte_cnt_d;
   logic           err_acc_q, err_acc_d;
   logic           stop_pend_q, stop_pend_d;
   logic           frame_err_q, frame_err_d;
   logic [15:0]    frame_cnt_q, frame_cnt_d;
   logic           capture_en_q, busy_q, frame_start_q, frame_done_q;
   logic           start_d, done_d;

   logic vs_rise, vs_fall, hr_fall;
   assign vs_rise = vsync & ~vsync_q;
   assign vs_fall = ~vsync & vsync_q;
   assign hr_fall = ~href & href_q;

   always_comb begin
      state_d     = state_q;
      skip_cnt_d  = skip_cnt_q;
      cont_d      = cont_q;
      line_cnt_d  = line_cnt_q;
      byte_cnt_d  = byte_cnt_q;
      err_acc_d   = err_acc_q;
      stop_pend_d = stop_pend_q;
      frame_err_d = frame_err_q;
      frame_cnt_d = frame_cnt_q;
      start_d     = 1'b0;
      done_d      = 1'b0;
      // Losing config aborts from any state, without completing the frame.
      if (!config_done) begin
         state_d = WAIT_CFG;
      end else begin
         case (state_q)
            WAIT_CFG: begin
               skip_cnt_d = '0;
               state_d    = (SKIP_FRAMES == 0) ? IDLE : SKIP;
            end
            SKIP: begin
               if (vs_rise) begin
                  if (skip_cnt_q == SKIP_LAST) state_d = IDLE;
                  else skip_cnt_d = skip_cnt_q + 1'b1;
               end
            end
            IDLE: begin
               if (start && !stop) begin
                  cont_d  = continuous;
                  state_d = ARM;
               end
            end
            ARM: begin
               if (stop) begin
                  state_d = IDLE;
               end else if (vs_fall) begin
                  state_d     = ACTIVE;
                  start_d     = 1'b1;
                  line_cnt_d  = '0;
                  byte_cnt_d  = '0;
                  err_acc_d   = 1'b0;
                  stop_pend_d = 1'b0;
               end
            end
            ACTIVE: begin
               if (stop) stop_pend_d = 1'b1;
               if (href && byte_cnt_q != 11'h7FF) byte_cnt_d = byte_cnt_q + 11'd1;
               if (hr_fall) begin
                  if (line_cnt_q != 10'h3FF) line_cnt_d = line_cnt_q + 10'd1;
                  if (byte_cnt_q != EXP_B) err_acc_d = 1'b1;
                  byte_cnt_d = '0;
               end
               if (vs_rise) begin
                  done_d      = 1'b1;
                  frame_err_d = err_acc_d || (line_cnt_q != EXP_L) || href;
                  frame_cnt_d = frame_cnt_q + 16'd1;
                  state_d     = (cont_q && !stop_pend_q && !stop) ? ARM : IDLE;
               end
            end
            default: state_d = WAIT_CFG;
         endcase
      end
   end

   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         state_q       <= WAIT_CFG;
         vsync_q       <= 1'b0;
         href_q        <= 1'b0;
         skip_cnt_q    <= '0;
         cont_q        <= 1'b0;
         line_cnt_q    <= '0;
         byte_cnt_q    <= '0;
         err_acc_q     <= 1'b0;
         stop_pend_q   <= 1'b0;
         frame_err_q   <= 1'b0;
         frame_cnt_q   <= '0;
         capture_en_q  <= 1'b0;
         busy_q        <= 1'b0;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         vsync_q       <= vsync;
         href_q        <= href;
         skip_cnt_q    <= skip_cnt_d;
         cont_q        <= cont_d;
         line_cnt_q    <= line_cnt_d;
         byte_cnt_q    <= byte_cnt_d;
         err_acc_q     <= err_acc_d;
         stop_pend_q   <= stop_pend_d;
         frame_err_q   <= frame_err_d;
         frame_cnt_q   <= frame_cnt_d;
         capture_en_q  <= (state_d == ACTIVE);
         busy_q        <= (state_d == ARM) || (state_d == ACTIVE);
         frame_start_q <= start_d;
         frame_done_q  <= done_d;
      end
   end

   assign capture_en  = capture_en_q;
   assign busy        = busy_q;
   assign frame_start = frame_start_q;
   assign frame_done  = frame_done_q;
   assign frame_err   = frame_err_q;
   assign frame_count = frame_cnt_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_cam_frame_ctrl.sv
// Bench for cam_frame_ctrl with a reduced frame geometry (6 lines x 10 bytes) to keep runs short.
module tb_cam_frame_ctrl;

   localparam int SKIPF = 2;
   localparam int EL    = 6;
   localparam int EB    = 10;
   localparam int FLEN  = 2 + EL * (EB + 2);

   logic        pclk = 1'b0;
   logic        reset, config_done, vsync, href, start, stop, continuous;
   logic        capture_en, busy, frame_start, frame_done, frame_err;
   logic [15:0] frame_count;
   logic [2:0]  state_dbg;

   cam_frame_ctrl #(.SKIP_FRAMES(SKIPF), .EXP_LINES(EL), .EXP_BYTES(EB)) dut (
      .pclk(pclk), .reset(reset), .config_done(config_done), .vsync(vsync), .href(href),
      .start(start), .stop(stop), .continuous(continuous), .capture_en(capture_en),
      .busy(busy), .frame_start(frame_start), .frame_done(frame_done), .frame_err(frame_err),
      .frame_count(frame_count), .state_dbg(state_dbg)
   );

   always #5 pclk = ~pclk;

   int checks = 0;
   int errors = 0;
   int nprint = 0;
   bit chk_en = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (nprint < 40) $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
         nprint++;
      end
   endtask

   // Frame-level reference: phases by number, lines recorded as a list of lengths.
   int  m_phase, m_seen, m_cur, m_cnt;
   bit  m_cont, m_stopreq, m_err, m_done, m_start, p_vs, p_hr, vr, vf, hf, bad;
   int  m_lens[$];

   always @(posedge pclk or negedge reset) begin
      if (!reset) begin
         m_phase = 0; m_seen = 0; m_cur = 0; m_cnt = 0;
         m_cont = 0; m_stopreq = 0; m_err = 0; m_done = 0; m_start = 0;
         p_vs = 0; p_hr = 0;
         m_lens.delete();
      end else begin
         vr = vsync && !p_vs;
         vf = !vsync && p_vs;
         hf = !href && p_hr;
         m_start = 0;
         m_done  = 0;
         if (!config_done) m_phase = 0;
         else case (m_phase)
            0: begin m_seen = 0; m_phase = (SKIPF == 0) ? 2 : 1; end
            1: if (vr) begin m_seen++; if (m_seen == SKIPF) m_phase = 2; end
            2: if (start && !stop) begin m_cont = continuous; m_phase = 3; end
            3: if (stop) m_phase = 2;
               else if (vf) begin
                  m_phase = 4; m_start = 1; m_lens.delete(); m_cur = 0; m_stopreq = 0;
               end
            4: begin
               if (stop) m_stopreq = 1;
               if (href) m_cur++;
               if (hf) begin m_lens.push_back(m_cur); m_cur = 0; end
               if (vr) begin
                  bad = (m_lens.size() != EL) || href;
                  foreach (m_lens[i]) if (m_lens[i] != EB) bad = 1;
                  m_err = bad;
                  m_done = 1;
                  m_cnt = (m_cnt + 1) % 65536;
                  m_phase = (m_cont && !m_stopreq && !stop) ? 3 : 2;
               end
            end
            default: m_phase = 0;
         endcase
         p_vs = vsync;
         p_hr = href;
      end
   end

   always @(negedge pclk) begin
      if (chk_en) begin
         chk("state_dbg",   state_dbg,   m_phase);
         chk("capture_en",  capture_en,  m_phase == 4);
         chk("busy",        busy,        m_phase == 3 || m_phase == 4);
         chk("frame_start", frame_start, m_start);
         chk("frame_done",  frame_done,  m_done);
         chk("frame_err",   frame_err,   m_err);
         chk("frame_count", frame_count, m_cnt);
      end
   end

   int cap_cycles = 0, start_pulses = 0, done_pulses = 0;
   always @(negedge pclk) begin
      if (capture_en)  cap_cycles++;
      if (frame_start) start_pulses++;
      if (frame_done)  done_pulses++;
   end

   task automatic cyc(input logic vs, input logic hr);
      @(negedge pclk);
      vsync = vs; href = hr; start = 1'b0; stop = 1'b0;
   endtask

   task automatic vblank(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0);
   endtask

   task automatic pulse(input logic st, input logic sp, input logic cont);
      @(negedge pclk);
      start = st; stop = sp; continuous = cont;
   endtask

   task automatic frame(input int nlines, input int short_line, input int short_by, input int stop_line);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      for (int l = 0; l < nlines; l++) begin
         int nb;
         nb = (l == short_line) ? EB - short_by : EB;
         for (int b = 0; b < nb; b++) cyc(1'b0, 1'b1);
         cyc(1'b0, 1'b0);
         if (l == stop_line) stop = 1'b1;
         cyc(1'b0, 1'b0);
      end
   endtask

   task automatic settle();
      @(posedge pclk);
      #1;
   endtask

   int c0, s0, d0;

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      reset = 0; config_done = 0; vsync = 0; href = 0; start = 0; stop = 0; continuous = 0;
      #12;
      chk("rst_state", state_dbg, 0);
      chk("rst_capture_en", capture_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_frame_count", frame_count, 0);
      @(negedge pclk);
      reset = 1;
      chk_en = 1;

      // Config, start during skip frames (ignored), two skipped frames.
      vblank(2);
      config_done = 1;
      vblank(2);
      pulse(1, 0, 0);
      vblank(1);
      frame(EL, -1, 0, -1); vblank(3);
      frame(EL, -1, 0, -1); vblank(3);
      settle();
      chk("skip_to_idle", state_dbg, 2);
      chk("skip_no_start", start_pulses, 0);
      chk("skip_no_capture", cap_cycles, 0);

      // Nominal single shot.
      c0 = cap_cycles; s0 = start_pulses; d0 = done_pulses;
      pulse(1, 0, 0); vblank(2);
      frame(EL, -1, 0, -1); vblank(3);
      frame(EL, -1, 0, -1); vblank(3);
      settle();
      chk("single_cap_len", cap_cycles - c0, FLEN);
      chk("single_starts", start_pulses - s0, 1);
      chk("single_dones", done_pulses - d0, 1);
      chk("single_err", frame_err, 0);
      chk("single_count", frame_count, 1);
      chk("single_idle", state_dbg, 2);

      // Start and stop together in IDLE.
      pulse(1, 1, 0); vblank(2);
      settle();
      chk("startstop_idle", state_dbg, 2);
      chk("startstop_busy", busy, 0);

      // Stop while armed.
      c0 = cap_cycles;
      pulse(1, 0, 0); vblank(1);
      pulse(0, 1, 0); vblank(1);
      frame(EL, -1, 0, -1); vblank(3);
      settle();
      chk("armstop_no_cap", cap_cycles - c0, 0);
      chk("armstop_idle", state_dbg, 2);

      // Continuous with stop in the middle of frame 2.
      c0 = cap_cycles; d0 = done_pulses;
      pulse(1, 0, 1); vblank(2);
      frame(EL, -1, 0, -1); vblank(3);
      frame(EL, -1, 0, 2);  vblank(3);
      frame(EL, -1, 0, -1); vblank(3);
      settle();
      chk("cont_dones", done_pulses - d0, 2);
      chk("cont_cap_len", cap_cycles - c0, 2 * FLEN);
      chk("cont_count", frame_count, 3);
      chk("cont_idle", state_dbg, 2);

      // Short line, then a clean frame in continuous mode.
      pulse(1, 0, 1); vblank(2);
      frame(EL, 3, 2, -1); vblank(3);
      settle();
      chk("shortline_err", frame_err, 1);
      frame(EL, -1, 0, -1); vblank(3);
      settle();
      chk("clean_err", frame_err, 0);
      pulse(0, 1, 0); vblank(1);
      settle();
      chk("clean_count", frame_count, 5);
      chk("clean_idle", state_dbg, 2);

      // Short frame.
      pulse(1, 0, 0); vblank(2);
      frame(EL - 1, -1, 0, -1); vblank(3);
      settle();
      chk("shortframe_err", frame_err, 1);
      chk("shortframe_count", frame_count, 6);

      // Config lost mid-frame.
      d0 = done_pulses;
      pulse(1, 0, 0); vblank(1);
      cyc(0, 0); cyc(0, 0);
      for (int i = 0; i < 15; i++) cyc(0, 1);
      config_done = 0;
      settle();
      chk("cfgdrop_state", state_dbg, 0);
      chk("cfgdrop_cap", capture_en, 0);
      cyc(0, 0); cyc(0, 0); vblank(3);
      settle();
      chk("cfgdrop_no_done", done_pulses - d0, 0);
      chk("cfgdrop_count", frame_count, 6);

      // Recover, capture, then async reset mid-frame.
      config_done = 1;
      vblank(2);
      frame(EL, -1, 0, -1); vblank(3);
      frame(EL, -1, 0, -1); vblank(3);
      pulse(1, 0, 0); vblank(1);
      cyc(0, 0); cyc(0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 1);
      settle();
      chk("prereset_busy", busy, 1);
      @(negedge pclk);
      #2;
      reset = 0;
      #1;
      chk("arst_capture_en", capture_en, 0);
      chk("arst_busy", busy, 0);
      chk("arst_frame_err", frame_err, 0);
      chk("arst_frame_count", frame_count, 0);
      chk("arst_state", state_dbg, 0);
      repeat (3) @(negedge pclk);
      reset = 1;
      repeat (4) @(negedge pclk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cam_frame_ctrl.md
Name: cam_frame_ctrl

Overview:
Frame-level sequencer for the camera capture datapath, running in the pclk domain after sensor configuration.
- Waits for configuration to finish, then discards a fixed number of settling frames.
- Arms capture on a software start and gates the capture path with capture_en on exact frame boundaries, in single-shot or continuous mode.
- Checks line and byte counts per frame and reports completion, error and frame count to the rest of the system.

Parameters:
- SKIP_FRAMES, 2: complete frames discarded after config_done rises, before start is accepted.
- EXP_LINES, 480: expected href lines per frame.
- EXP_BYTES, 1280: expected pclk cycles with href high per line (2 bytes per pixel, 640 pixels).

Ports:
- pclk, input, 1: camera pixel clock; the only clock.
- reset, input, 1: asynchronous, active-low reset.
- config_done, input, 1: sensor register configuration complete (level).
- vsync, input, 1: camera vsync; high = vertical blanking.
- href, input, 1: camera href; high = active line bytes.
- start, input, 1: single-cycle request to begin capture.
- stop, input, 1: single-cycle request to end capture.
- continuous, input, 1: 1 = re-arm after each frame; 0 = single shot. Sampled when start is accepted.
- capture_en, output, 1: enables the capture datapath; high only during accepted active frames.
- busy, output, 1: high in ARM or ACTIVE.
- frame_start, output, 1: one-cycle pulse on entry to ACTIVE.
- frame_done, output, 1: one-cycle pulse when a captured frame completes.
- frame_err, output, 1: error status of the last completed frame.
- frame_count, output, 16: number of completed frames.
- state_dbg, output, 3: current state encoding.

Behaviour:
- Clocking and reset: all registers are clocked on posedge pclk. On reset low, every register clears asynchronously. Output values in reset: state = WAIT_CFG, capture_en = 0, busy = 0, frame_start = 0, frame_done = 0, frame_err = 0, frame_count = 0.
- Edge detection: vsync_q and href_q are registered copies of the inputs; both reset to 0.
  - vs_rise = vsync & ~vsync_q
  - vs_fall = ~vsync & vsync_q
  - hr_fall = ~href & href_q
- State encoding (state_dbg): WAIT_CFG = 0, SKIP = 1, IDLE = 2, ARM = 3, ACTIVE = 4. State transitions are registered.
- WAIT_CFG: all edges are ignored. On config_done = 1, go to SKIP and clear skip_cnt. If SKIP_FRAMES = 0, go directly to IDLE.
- SKIP: on each vs_rise, increment skip_cnt. On the vs_rise where skip_cnt = SKIP_FRAMES-1, go to IDLE.
- IDLE: on start = 1 and stop = 0, latch continuous into cont_r and go to ARM. If start and stop arrive together, stop wins and the state stays IDLE.
- ARM: on vs_fall, go to ACTIVE. On entry to ACTIVE, clear line_cnt, byte_cnt, err_acc and stop_pend. On stop in ARM, go to IDLE. start is ignored in ARM.
- ACTIVE:
  - capture_en = 1.
  - byte_cnt (11 bits, saturates at 2047) increments on each cycle with href = 1.
  - On hr_fall:
    - increment line_cnt (10 bits, saturates at 1023);
    - if byte_cnt != EXP_BYTES, set err_acc;
    - clear byte_cnt.
  - stop in ACTIVE sets stop_pend; the current frame always finishes.
  - On vs_rise, the frame completes:
    - if line_cnt != EXP_LINES or href = 1, set the error;
    - frame_done pulses for one cycle and frame_err is updated to the frame's error;
    - frame_count increments, wrapping from 0xFFFF to 0;
    - next state is ARM if cont_r = 1 and stop_pend = 0 and stop = 0; otherwise IDLE.
- Output timing: capture_en, busy, frame_start and frame_done are registered outputs.
  - capture_en rises in the cycle after the vs_fall edge is detected.
  - capture_en falls in the cycle after vs_rise is detected.
  - frame_start and frame_done are single-cycle pulses aligned to those same cycles.
- frame_err holds its value until the next frame_done.
- config_done falling, in any state: go to WAIT_CFG on the next cycle. capture_en drops and no frame_done is issued; frame_count is retained.
- Reset low mid-frame: immediate return to reset values. No frame_done is issued.

Test Plan:
- Nominal single shot (SKIP_FRAMES = 2, config_done rising, 2 full frames, start with continuous = 0, one 480×1280 frame) -> no capture_en during the skip frames; frame_start once; capture_en high for exactly the active region; frame_done once; frame_err = 0; frame_count = 1; returns to IDLE; the following frame is not captured.
- Continuous with stop (continuous = 1, 3 frames, stop pulse mid-frame 2) -> frame_done ×2; frame_count = 2; capture_en low after frame 2's vs_rise; frame 3 not captured; state = IDLE.
- Short line (line 100 has 1278 bytes) -> frame_done with frame_err = 1. The next clean frame (continuous) gives frame_err = 0.
- Short frame (vs_rise after 479 lines) -> frame_err = 1; frame_count still increments.
- Boundary cases:
  - start and stop in the same cycle in IDLE -> stays IDLE.
  - stop in ARM -> IDLE, and capture_en is never asserted.
  - start before the skip frames finish -> ignored.
- Abort cases:
  - config_done drop mid-ACTIVE -> WAIT_CFG next cycle, capture_en = 0, no frame_done.
  - async reset low mid-frame -> all outputs 0 immediately without a pclk edge; frame_count = 0.
